// File: rtl/ref_pkg.sv
// Shared constants and state encoding for the DRAM refresh request timer.
// Default parameters live here so the top and the interval counter agree.
package ref_pkg;

   localparam int REF_PERIOD_DEF = 375;
   localparam int URG_DEBT_DEF   = 2;
   localparam int MAX_DEBT_DEF   = 7;
   localparam int DEBT_W         = 3;

   localparam logic [1:0] ST_IDLE = 2'd0;
   localparam logic [1:0] ST_PEND = 2'd1;
   localparam logic [1:0] ST_GAP  = 2'd2;

   typedef enum logic [1:0] {
      IDLE = ST_IDLE,
      PEND = ST_PEND,
      GAP  = ST_GAP
   } ref_state_e;

endpackage

// File: rtl/ref_interval.sv
// Free-running refresh interval counter: counts 0..REF_PERIOD-1 and flags
// the wrap cycle with a one-cycle Tick.
module ref_interval
   import ref_pkg::*;
#(
   parameter int REF_PERIOD = REF_PERIOD_DEF
) (
   input  logic CLK,
   input  logic RST,
   output logic Tick
);

   localparam int IC_W = (REF_PERIOD > 1) ? $clog2(REF_PERIOD) : 1;
   localparam logic [IC_W-1:0] IC_LAST = IC_W'(REF_PERIOD - 1);

   logic [IC_W-1:0] r_ic;
   logic            w_wrap;

   assign w_wrap = (r_ic == IC_LAST);
   assign Tick   = w_wrap;

   always_ff @(posedge CLK) begin
      if (RST) begin
         r_ic <= '0;
      end else if (w_wrap) begin
         r_ic <= '0;
      end else begin
         r_ic <= r_ic + 1'b1;
      end
   end

endmodule

// File: rtl/ram_refresh_timer.sv
// Refresh debt tracker driving RefReq/RefUrg into the RAM controller; one
// refresh retired per acknowledge edge, with a forced request-low gap.
//
//   state | meaning
//   ------+-----------------------------------------------------------
//   IDLE  | no refresh owed, requests low
//   PEND  | debt >= 1, RefReq high, RefUrg high when debt >= URG_DEBT
//   GAP   | ack seen, requests held low until RefAck drops
module ram_refresh_timer
   import ref_pkg::*;
#(
   parameter int REF_PERIOD = REF_PERIOD_DEF,
   parameter int URG_DEBT   = URG_DEBT_DEF,
   parameter int MAX_DEBT   = MAX_DEBT_DEF
) (
   input  logic              CLK,
   input  logic              RST,
   input  logic              RefAck,
   output logic              RefReq,
   output logic              RefUrg,
   output logic [DEBT_W-1:0] RefDebt,
   output logic              RefOverrun
);

   localparam logic [DEBT_W-1:0] URG_D = DEBT_W'(URG_DEBT);
   localparam logic [DEBT_W-1:0] MAX_D = DEBT_W'(MAX_DEBT);

   logic              w_tick;
   logic              w_ae;
   logic              w_ovr_set;
   logic [DEBT_W-1:0] w_debt_nxt;
   ref_state_e        w_state_nxt;

   logic              r_ack_prev;
   logic [DEBT_W-1:0] r_debt;
   ref_state_e        r_state;
   logic              r_req;
   logic              r_urg;
   logic              r_ovr;

   ref_interval #(
      .REF_PERIOD (REF_PERIOD)
   ) u_interval (
      .CLK  (CLK),
      .RST  (RST),
      .Tick (w_tick)
   );

   assign w_ae = RefAck & ~r_ack_prev;

   always_comb begin
      w_debt_nxt = r_debt;
      w_ovr_set  = 1'b0;
      if (w_tick && !w_ae) begin
         if (r_debt >= MAX_D) begin
            w_ovr_set = 1'b1;
         end else begin
            w_debt_nxt = r_debt + 1'b1;
         end
      end else if (w_ae && !w_tick && (r_debt != '0)) begin
         w_debt_nxt = r_debt - 1'b1;
      end
   end

   // Next state is taken from next debt so outputs move on the same edge.
   always_comb begin
      w_state_nxt = r_state;
      case (r_state)
         IDLE: if (w_debt_nxt != '0) w_state_nxt = PEND;
         PEND: if (w_ae) w_state_nxt = GAP;
         GAP:  if (!RefAck) w_state_nxt = (w_debt_nxt != '0) ? PEND : IDLE;
         default: w_state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge CLK) begin
      if (RST) begin
         r_ack_prev <= 1'b0;
         r_debt     <= '0;
         r_state    <= IDLE;
         r_req      <= 1'b0;
         r_urg      <= 1'b0;
         r_ovr      <= 1'b0;
      end else begin
         r_ack_prev <= RefAck;
         r_debt     <= w_debt_nxt;
         r_state    <= w_state_nxt;
         r_req      <= (w_state_nxt == PEND);
         r_urg      <= (w_state_nxt == PEND) && (w_debt_nxt >= URG_D);
         r_ovr      <= r_ovr | w_ovr_set;
      end
   end

   assign RefReq     = r_req;
   assign RefUrg     = r_urg;
   assign RefDebt    = r_debt;
   assign RefOverrun = r_ovr;

endmodule

// File: tb/tb_ram_refresh_timer.sv
// Scenario bench for ram_refresh_timer: expected output tuples are queued per
// stimulus row and popped for comparison after the sampled edge.
module tb_ram_refresh_timer;

   localparam int P = 375;

   logic       CLK = 1'b0;
   logic       RST = 1'b1;
   logic       RefAck = 1'b0;
   logic       RefReq;
   logic       RefUrg;
   logic [2:0] RefDebt;
   logic       RefOverrun;

   int n_total = 0;
   int n_pass  = 0;
   int edges   = 0;

   typedef struct {
      string      name;
      logic [5:0] v;
   } exp_t;

   typedef struct {
      string      name;
      int         at;
      logic       ack;
      logic [5:0] v;
   } row_t;

   exp_t sb[$];

   ram_refresh_timer #(
      .REF_PERIOD (P),
      .URG_DEBT   (2),
      .MAX_DEBT   (7)
   ) dut (
      .CLK        (CLK),
      .RST        (RST),
      .RefAck     (RefAck),
      .RefReq     (RefReq),
      .RefUrg     (RefUrg),
      .RefDebt    (RefDebt),
      .RefOverrun (RefOverrun)
   );

   always #5 CLK = ~CLK;

   initial begin
      #2_000_000;
      $display("FAIL watchdog: got timeout want finish");
      $fatal(1);
   end

   function automatic logic [5:0] pk(input logic req, input logic urg,
                                     input logic [2:0] d, input logic ovr);
      return {req, urg, d, ovr};
   endfunction

   task automatic step(input int n);
      repeat (n) begin
         @(posedge CLK);
         #1;
         edges++;
      end
   endtask

   task automatic adv_to(input int t);
      while (edges < t) step(1);
   endtask

   task automatic test_reset();
      exp_t e;
      logic [5:0] got;
      RST = 1'b1;
      RefAck = 1'b0;
      sb.push_back('{"reset", pk(0, 0, 3'd0, 0)});
      step(2);
      e = sb.pop_front();
      got = {RefReq, RefUrg, RefDebt, RefOverrun};
      n_total++;
      if (got !== e.v)
         $display("FAIL %s: got req/urg/debt/ovr=%b/%b/%0d/%b want %b/%b/%0d/%b",
                  e.name, got[5], got[4], got[3:1], got[0], e.v[5], e.v[4], e.v[3:1], e.v[0]);
      else n_pass++;
      RST = 1'b0;
      edges = 0;
   endtask

   task automatic test_first_request();
      exp_t e;
      logic [5:0] got;
      row_t rows[3] = '{
         '{"pre_first_tick", P - 1,   1'b0, pk(0, 0, 3'd0, 0)},
         '{"first_tick",     P,       1'b0, pk(1, 0, 3'd1, 0)},
         '{"second_tick",    2 * P,   1'b0, pk(1, 1, 3'd2, 0)}
      };
      foreach (rows[i]) begin
         adv_to(rows[i].at - 1);
         RefAck = rows[i].ack;
         sb.push_back('{rows[i].name, rows[i].v});
         step(1);
         e = sb.pop_front();
         got = {RefReq, RefUrg, RefDebt, RefOverrun};
         n_total++;
         if (got !== e.v)
            $display("FAIL %s: got req/urg/debt/ovr=%b/%b/%0d/%b want %b/%b/%0d/%b",
                     e.name, got[5], got[4], got[3:1], got[0], e.v[5], e.v[4], e.v[3:1], e.v[0]);
         else n_pass++;
      end
   endtask

   task automatic test_ack_pending();
      exp_t e;
      logic [5:0] got;
      row_t rows[4] = '{
         '{"debt3",        3 * P,     1'b0, pk(1, 1, 3'd3, 0)},
         '{"ack_edge_gap", 3 * P + 1, 1'b1, pk(0, 0, 3'd2, 0)},
         '{"ack_held_gap", 3 * P + 2, 1'b1, pk(0, 0, 3'd2, 0)},
         '{"rerise_urg",   3 * P + 3, 1'b0, pk(1, 1, 3'd2, 0)}
      };
      foreach (rows[i]) begin
         adv_to(rows[i].at - 1);
         RefAck = rows[i].ack;
         sb.push_back('{rows[i].name, rows[i].v});
         step(1);
         e = sb.pop_front();
         got = {RefReq, RefUrg, RefDebt, RefOverrun};
         n_total++;
         if (got !== e.v)
            $display("FAIL %s: got req/urg/debt/ovr=%b/%b/%0d/%b want %b/%b/%0d/%b",
                     e.name, got[5], got[4], got[3:1], got[0], e.v[5], e.v[4], e.v[3:1], e.v[0]);
         else n_pass++;
      end
   endtask

   task automatic test_ack_to_idle();
      exp_t e;
      logic [5:0] got;
      row_t rows[6] = '{
         '{"short_ack_gap",  3 * P + 4,  1'b1, pk(0, 0, 3'd1, 0)},
         '{"pend_debt1",     3 * P + 5,  1'b0, pk(1, 0, 3'd1, 0)},
         '{"last_ack_gap",   3 * P + 6,  1'b1, pk(0, 0, 3'd0, 0)},
         '{"held_no_dec",    3 * P + 7,  1'b1, pk(0, 0, 3'd0, 0)},
         '{"idle_after_gap", 3 * P + 8,  1'b0, pk(0, 0, 3'd0, 0)},
         '{"idle_stays",     3 * P + 15, 1'b0, pk(0, 0, 3'd0, 0)}
      };
      foreach (rows[i]) begin
         adv_to(rows[i].at - 1);
         RefAck = rows[i].ack;
         sb.push_back('{rows[i].name, rows[i].v});
         step(1);
         e = sb.pop_front();
         got = {RefReq, RefUrg, RefDebt, RefOverrun};
         n_total++;
         if (got !== e.v)
            $display("FAIL %s: got req/urg/debt/ovr=%b/%b/%0d/%b want %b/%b/%0d/%b",
                     e.name, got[5], got[4], got[3:1], got[0], e.v[5], e.v[4], e.v[3:1], e.v[0]);
         else n_pass++;
      end
   endtask

   task automatic test_ack_tick_coincide();
      exp_t e;
      logic [5:0] got;
      row_t rows[3] = '{
         '{"pre_coincide",   6 * P - 1, 1'b0, pk(1, 1, 3'd2, 0)},
         '{"coincide_gap",   6 * P,     1'b1, pk(0, 0, 3'd2, 0)},
         '{"after_coincide", 6 * P + 1, 1'b0, pk(1, 1, 3'd2, 0)}
      };
      foreach (rows[i]) begin
         adv_to(rows[i].at - 1);
         RefAck = rows[i].ack;
         sb.push_back('{rows[i].name, rows[i].v});
         step(1);
         e = sb.pop_front();
         got = {RefReq, RefUrg, RefDebt, RefOverrun};
         n_total++;
         if (got !== e.v)
            $display("FAIL %s: got req/urg/debt/ovr=%b/%b/%0d/%b want %b/%b/%0d/%b",
                     e.name, got[5], got[4], got[3:1], got[0], e.v[5], e.v[4], e.v[3:1], e.v[0]);
         else n_pass++;
      end
   endtask

   task automatic test_saturation();
      exp_t e;
      logic [5:0] got;
      row_t rows[8] = '{
         '{"debt3_sat",    7 * P,      1'b0, pk(1, 1, 3'd3, 0)},
         '{"debt4",        8 * P,      1'b0, pk(1, 1, 3'd4, 0)},
         '{"debt5",        9 * P,      1'b0, pk(1, 1, 3'd5, 0)},
         '{"debt6",        10 * P,     1'b0, pk(1, 1, 3'd6, 0)},
         '{"debt7",        11 * P,     1'b0, pk(1, 1, 3'd7, 0)},
         '{"overrun_set",  12 * P,     1'b0, pk(1, 1, 3'd7, 1)},
         '{"ack_keeps_ov", 12 * P + 1, 1'b1, pk(0, 0, 3'd6, 1)},
         '{"ov_sticky",    12 * P + 2, 1'b0, pk(1, 1, 3'd6, 1)}
      };
      foreach (rows[i]) begin
         adv_to(rows[i].at - 1);
         RefAck = rows[i].ack;
         sb.push_back('{rows[i].name, rows[i].v});
         step(1);
         e = sb.pop_front();
         got = {RefReq, RefUrg, RefDebt, RefOverrun};
         n_total++;
         if (got !== e.v)
            $display("FAIL %s: got req/urg/debt/ovr=%b/%b/%0d/%b want %b/%b/%0d/%b",
                     e.name, got[5], got[4], got[3:1], got[0], e.v[5], e.v[4], e.v[3:1], e.v[0]);
         else n_pass++;
      end
   endtask

   task automatic test_reset_in_gap();
      exp_t e;
      logic [5:0] got;
      row_t rows[4] = '{
         '{"ack_debt0_ign", 11,    1'b1, pk(0, 0, 3'd0, 0)},
         '{"idle_after_ign", 12,   1'b0, pk(0, 0, 3'd0, 0)},
         '{"post_rst_pre",  P - 1, 1'b0, pk(0, 0, 3'd0, 0)},
         '{"post_rst_req",  P,     1'b0, pk(1, 0, 3'd1, 0)}
      };
      adv_to(12 * P + 2);
      RefAck = 1'b1;
      sb.push_back('{"gap_debt5", pk(0, 0, 3'd5, 1)});
      step(1);
      e = sb.pop_front();
      got = {RefReq, RefUrg, RefDebt, RefOverrun};
      n_total++;
      if (got !== e.v)
         $display("FAIL %s: got req/urg/debt/ovr=%b/%b/%0d/%b want %b/%b/%0d/%b",
                  e.name, got[5], got[4], got[3:1], got[0], e.v[5], e.v[4], e.v[3:1], e.v[0]);
      else n_pass++;
      RST = 1'b1;
      sb.push_back('{"rst_in_gap", pk(0, 0, 3'd0, 0)});
      step(1);
      e = sb.pop_front();
      got = {RefReq, RefUrg, RefDebt, RefOverrun};
      n_total++;
      if (got !== e.v)
         $display("FAIL %s: got req/urg/debt/ovr=%b/%b/%0d/%b want %b/%b/%0d/%b",
                  e.name, got[5], got[4], got[3:1], got[0], e.v[5], e.v[4], e.v[3:1], e.v[0]);
      else n_pass++;
      RST = 1'b0;
      RefAck = 1'b0;
      edges = 0;
      foreach (rows[i]) begin
         adv_to(rows[i].at - 1);
         RefAck = rows[i].ack;
         sb.push_back('{rows[i].name, rows[i].v});
         step(1);
         e = sb.pop_front();
         got = {RefReq, RefUrg, RefDebt, RefOverrun};
         n_total++;
         if (got !== e.v)
            $display("FAIL %s: got req/urg/debt/ovr=%b/%b/%0d/%b want %b/%b/%0d/%b",
                     e.name, got[5], got[4], got[3:1], got[0], e.v[5], e.v[4], e.v[3:1], e.v[0]);
         else n_pass++;
      end
   endtask

   initial begin
      test_reset();
      test_first_request();
      test_ack_pending();
      test_ack_to_idle();
      test_ack_tick_coincide();
      test_saturation();
      test_reset_in_gap();
      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
